// File: rtl/c17_pipe_if.sv
// Valid/ready bus for the c17 pipeline array: input word stream, result stream and delivery count.
interface c17_pipe_if #(
  parameter int unsigned LANES = 4
);
  localparam int unsigned IN_W  = LANES * 5;
  localparam int unsigned OUT_W = LANES * 2;
  localparam int unsigned CNT_W = 16;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/c17_pipe_array.sv
// Multi-lane ISCAS c17 datapath with selectable internal register cuts and a single global stall.
module c17_pipe_array #(
  parameter int unsigned LANES    = 4,
  parameter logic [1:0]  PIPE_CUT = 2'b11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  c17_pipe_if.slave   bus
);
  localparam int unsigned IN_W  = LANES * 5;
  localparam int unsigned OUT_W = LANES * 2;
  localparam int unsigned CNT_W = 16;

  logic adv;
  logic load;

  // Every stage moves together; nothing moves while a result sits unaccepted.
  assign adv          = bus.out_ready | ~bus.out_valid;
  assign load         = adv & ~flush;
  assign bus.in_ready = adv;

  // ---------------- S0: input register ----------------
  logic [IN_W-1:0]  s0_data;
  logic             s0_valid;
  logic [LANES-1:0] s0_n1, s0_n2, s0_n3, s0_n6, s0_n7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_data  <= '0;
      s0_valid <= 1'b0;
    end else begin
      if (flush)    s0_valid <= 1'b0;
      else if (adv) s0_valid <= bus.in_valid;
      if (load)     s0_data  <= bus.in_data;
    end
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_unpack
    assign s0_n1[g] = s0_data[5*g+0];
    assign s0_n2[g] = s0_data[5*g+1];
    assign s0_n3[g] = s0_data[5*g+2];
    assign s0_n6[g] = s0_data[5*g+3];
    assign s0_n7[g] = s0_data[5*g+4];
  end

  // ---------------- NAND level 1 and optional S1 cut ----------------
  logic [LANES-1:0] l1_n10, l1_n11;
  logic [LANES-1:0] s1_n10, s1_n11, s1_n2, s1_n7;
  logic             s1_valid;

  assign l1_n10 = ~(s0_n1 & s0_n3);
  assign l1_n11 = ~(s0_n3 & s0_n6);

  if (PIPE_CUT[0]) begin : g_cut1
    // N2 and N7 travel with the level-1 results so level 2 sees one consistent word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_n10   <= '0;
        s1_n11   <= '0;
        s1_n2    <= '0;
        s1_n7    <= '0;
        s1_valid <= 1'b0;
      end else begin
        if (flush)    s1_valid <= 1'b0;
        else if (adv) s1_valid <= s0_valid;
        if (load) begin
          s1_n10 <= l1_n10;
          s1_n11 <= l1_n11;
          s1_n2  <= s0_n2;
          s1_n7  <= s0_n7;
        end
      end
    end
  end else begin : g_nocut1
    assign s1_n10   = l1_n10;
    assign s1_n11   = l1_n11;
    assign s1_n2    = s0_n2;
    assign s1_n7    = s0_n7;
    assign s1_valid = s0_valid;
  end

  // ---------------- NAND level 2 and optional S2 cut ----------------
  logic [LANES-1:0] l2_n16, l2_n19;
  logic [LANES-1:0] s2_n10, s2_n16, s2_n19;
  logic             s2_valid;

  assign l2_n16 = ~(s1_n2  & s1_n11);
  assign l2_n19 = ~(s1_n11 & s1_n7);

  if (PIPE_CUT[1]) begin : g_cut2
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_n10   <= '0;
        s2_n16   <= '0;
        s2_n19   <= '0;
        s2_valid <= 1'b0;
      end else begin
        if (flush)    s2_valid <= 1'b0;
        else if (adv) s2_valid <= s1_valid;
        if (load) begin
          s2_n10 <= s1_n10;
          s2_n16 <= l2_n16;
          s2_n19 <= l2_n19;
        end
      end
    end
  end else begin : g_nocut2
    assign s2_n10   = s1_n10;
    assign s2_n16   = l2_n16;
    assign s2_n19   = l2_n19;
    assign s2_valid = s1_valid;
  end

  // ---------------- NAND level 3 and S3 output register ----------------
  logic [OUT_W-1:0] s3_next;
  logic [OUT_W-1:0] s3_data;
  logic             s3_valid;
  logic [CNT_W-1:0] count;

  for (genvar g = 0; g < int'(LANES); g++) begin : g_pack
    assign s3_next[2*g+0] = ~(s2_n10[g] & s2_n16[g]);
    assign s3_next[2*g+1] = ~(s2_n16[g] & s2_n19[g]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_data  <= '0;
      s3_valid <= 1'b0;
      count    <= '0;
    end else begin
      if (flush)    s3_valid <= 1'b0;
      else if (adv) s3_valid <= s2_valid;
      if (load)     s3_data  <= s3_next;
      // Delivery counter survives flush and wraps freely.
      if (s3_valid && bus.out_ready) count <= count + CNT_W'(1);
    end
  end

  assign bus.out_valid = s3_valid;
  assign bus.out_data  = s3_data;
  assign bus.out_count = count;
endmodule
